// File: rtl/downsizer_w_splitter.sv
// AXI write-data downsizer: splits each wide W beat into RATIO narrow beats,
// emitting the least-significant lane first, at one narrow beat per cycle.
module downsizer_w_splitter #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [S_DATA_WIDTH-1:0]   s_wdata,
    input  logic [S_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                      s_wlast,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [M_DATA_WIDTH-1:0]   m_wdata,
    output logic [M_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic                      busy_o
);

    localparam int RATIO    = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int CNT_W    = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int S_STRB_W = S_DATA_WIDTH / 8;
    localparam int M_STRB_W = M_DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    if ((RATIO < 2) || ((RATIO & (RATIO - 1)) != 0) ||
        ((S_DATA_WIDTH % M_DATA_WIDTH) != 0) || ((M_DATA_WIDTH % 8) != 0)) begin : g_bad_params
        $error("downsizer_w_splitter: width ratio must be a power of two >= 2 and M_DATA_WIDTH a multiple of 8");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [S_DATA_WIDTH-1:0] r_hold_data;
    logic [S_STRB_W-1:0]   r_hold_strb;
    logic                  r_hold_last;
    logic [CNT_W-1:0]      r_lane_cnt;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_lane_nxt;
    logic                  w_load;
    logic                  w_vld;
    logic                  w_last_lane;
    logic                  w_m_fire;
    logic                  w_s_fire;
    logic [M_DATA_WIDTH-1:0] w_lane_data;
    logic [M_STRB_W-1:0]   w_lane_strb;

    assign w_vld       = (r_state == ST_SEND);
    assign w_last_lane = (r_lane_cnt == LAST_LANE);
    assign w_m_fire    = w_vld & m_wready;

    // The final lane's handshake frees the holding stage in the same cycle,
    // which lets the next wide beat load with no bubble.
    assign s_wready = rst_n & (~w_vld | (w_m_fire & w_last_lane));
    assign w_s_fire = s_wvalid & s_wready;

    // NOTE: every signal written in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane_cnt;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s_fire) begin
                    w_load      = 1'b1;
                    w_lane_nxt  = '0;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_m_fire) begin
                    if (!w_last_lane) begin
                        w_lane_nxt = r_lane_cnt + CNT_W'(1);
                    end else if (w_s_fire) begin
                        w_load     = 1'b1;
                        w_lane_nxt = '0;
                    end else begin
                        w_lane_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lane_nxt  = '0;
            end
        endcase
    end

    // NOTE: reset is synchronous (sampled on the clock edge), and the holding
    // register is cleared too so the narrow outputs read zero after reset.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lane_cnt  <= '0;
            r_hold_data <= '0;
            r_hold_strb <= '0;
            r_hold_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_nxt;
            if (w_load) begin
                r_hold_data <= s_wdata;
                r_hold_strb <= s_wstrb;
                r_hold_last <= s_wlast;
            end
        end
    end

    always_comb begin
        w_lane_data = '0;
        w_lane_strb = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane_cnt == CNT_W'(i)) begin
                w_lane_data = r_hold_data[i*M_DATA_WIDTH +: M_DATA_WIDTH];
                w_lane_strb = r_hold_strb[i*M_STRB_W +: M_STRB_W];
            end
        end
    end

    assign m_wdata  = w_lane_data;
    assign m_wstrb  = w_lane_strb;
    assign m_wlast  = r_hold_last & w_last_lane;
    // Qualified by rst_n so an in-flight lane is never offered while reset is held.
    assign m_wvalid = w_vld & rst_n;
    assign busy_o   = w_vld & rst_n;

endmodule

// File: tb/tb_downsizer_w_splitter.sv
// Directed bench for downsizer_w_splitter: a vector table on a 64->32 instance
// plus a hand-written 128->32 sequence.
module tb_downsizer_w_splitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 64 -> 32 instance
    logic        rst_n;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready, busy_o;

    downsizer_w_splitter #(.S_DATA_WIDTH(64), .M_DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .busy_o(busy_o)
    );

    // 128 -> 32 instance
    logic         w_rst_n;
    logic [127:0] w_s_wdata;
    logic [15:0]  w_s_wstrb;
    logic         w_s_wlast, w_s_wvalid, w_s_wready;
    logic [31:0]  w_m_wdata;
    logic [3:0]   w_m_wstrb;
    logic         w_m_wlast, w_m_wvalid, w_m_wready, w_busy;

    downsizer_w_splitter #(.S_DATA_WIDTH(128), .M_DATA_WIDTH(32)) dut_wide (
        .clk(clk), .rst_n(w_rst_n),
        .s_wdata(w_s_wdata), .s_wstrb(w_s_wstrb), .s_wlast(w_s_wlast),
        .s_wvalid(w_s_wvalid), .s_wready(w_s_wready),
        .m_wdata(w_m_wdata), .m_wstrb(w_m_wstrb), .m_wlast(w_m_wlast),
        .m_wvalid(w_m_wvalid), .m_wready(w_m_wready), .busy_o(w_busy)
    );

    typedef struct {
        logic        rst_n;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        mready;
        logic        e_sready;
        logic        e_mvalid;
        logic        chk;      // compare data/strb/last in this cycle
        logic [31:0] e_data;
        logic [3:0]  e_strb;
        logic        e_last;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [63:0] d, input logic [7:0] s, input logic l,
                       input logic v, input logic mr, input logic esr, input logic emv,
                       input logic c, input logic [31:0] ed, input logic [3:0] es, input logic el);
        vec_t t;
        t.rst_n = r; t.wdata = d; t.wstrb = s; t.wlast = l; t.wvalid = v; t.mready = mr;
        t.e_sready = esr; t.e_mvalid = emv; t.chk = c; t.e_data = ed; t.e_strb = es; t.e_last = el;
        vecs.push_back(t);
    endtask

    localparam logic [63:0] SB = 64'h11223344_55667788;
    localparam logic [63:0] VA = 64'hAAAA0001_AAAA0000;
    localparam logic [63:0] VB = 64'hBBBB0001_BBBB0000;
    localparam logic [63:0] VC = 64'hCCCC0001_CCCC0000;
    localparam logic [63:0] VD = 64'hD4D3D2D1_C4C3C2C1;
    localparam logic [63:0] VE = 64'hEEEE0001_EEEE0000;
    localparam logic [63:0] VF = 64'h0F0F0002_0F0F0001;

    initial begin
        logic [31:0] exp_w [4];

        // Reset held 3 cycles with s_wvalid high
        add(0, SB, 8'hF0, 1, 1, 1,  0, 0, 1, 32'h0, 4'h0, 0);
        add(0, SB, 8'hF0, 1, 1, 1,  0, 0, 1, 32'h0, 4'h0, 0);
        add(0, SB, 8'hF0, 1, 1, 1,  0, 0, 1, 32'h0, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 0, 1, 32'h0, 4'h0, 0);
        // Single beat split, zero-strobe low lane
        add(1, SB, 8'hF0, 1, 1, 1,  1, 0, 1, 32'h0, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  0, 1, 1, 32'h55667788, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 1, 1, 32'h11223344, 4'hF, 1);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 0, 0, 32'h0, 4'h0, 0);
        // Back-to-back A, B, C
        add(1, VA, 8'hFF, 0, 1, 1,  1, 0, 0, 32'h0, 4'h0, 0);
        add(1, VB, 8'h0F, 0, 1, 1,  0, 1, 1, 32'hAAAA0000, 4'hF, 0);
        add(1, VB, 8'h0F, 0, 1, 1,  1, 1, 1, 32'hAAAA0001, 4'hF, 0);
        add(1, VC, 8'h3C, 1, 1, 1,  0, 1, 1, 32'hBBBB0000, 4'hF, 0);
        add(1, VC, 8'h3C, 1, 1, 1,  1, 1, 1, 32'hBBBB0001, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  0, 1, 1, 32'hCCCC0000, 4'hC, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 1, 1, 32'hCCCC0001, 4'h3, 1);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 0, 0, 32'h0, 4'h0, 0);
        // Backpressure on lane 1; upstream E waits until released
        add(1, VD, 8'h5A, 1, 1, 1,  1, 0, 0, 32'h0, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  0, 1, 1, 32'hC4C3C2C1, 4'hA, 0);
        add(1, VE, 8'hFF, 1, 1, 0,  0, 1, 1, 32'hD4D3D2D1, 4'h5, 1);
        add(1, VE, 8'hFF, 1, 1, 0,  0, 1, 1, 32'hD4D3D2D1, 4'h5, 1);
        add(1, VE, 8'hFF, 1, 1, 0,  0, 1, 1, 32'hD4D3D2D1, 4'h5, 1);
        add(1, VE, 8'hFF, 1, 1, 1,  1, 1, 1, 32'hD4D3D2D1, 4'h5, 1);
        // E lane 0 accepted, then reset before lane 1
        add(1, 64'h0, 8'h00, 0, 0, 1,  0, 1, 1, 32'hEEEE0000, 4'hF, 0);
        add(0, 64'h0, 8'h00, 0, 0, 1,  0, 0, 0, 32'h0, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 0, 1, 32'h0, 4'h0, 0);
        // Fresh beat after reset starts at lane 0
        add(1, VF, 8'h81, 0, 1, 1,  1, 0, 1, 32'h0, 4'h0, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  0, 1, 1, 32'h0F0F0001, 4'h1, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 1, 1, 32'h0F0F0002, 4'h8, 0);
        add(1, 64'h0, 8'h00, 0, 0, 1,  1, 0, 0, 32'h0, 4'h0, 0);

        rst_n = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; m_wready = 1'b1;
        w_rst_n = 1'b0; w_s_wdata = '0; w_s_wstrb = '0; w_s_wlast = 1'b0; w_s_wvalid = 1'b0; w_m_wready = 1'b1;

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst_n    = vecs[i].rst_n;
            s_wdata  = vecs[i].wdata;
            s_wstrb  = vecs[i].wstrb;
            s_wlast  = vecs[i].wlast;
            s_wvalid = vecs[i].wvalid;
            m_wready = vecs[i].mready;
            @(negedge clk);
            check($sformatf("v%0d s_wready", i), 128'(s_wready), 128'(vecs[i].e_sready));
            check($sformatf("v%0d m_wvalid", i), 128'(m_wvalid), 128'(vecs[i].e_mvalid));
            check($sformatf("v%0d busy_o", i),   128'(busy_o),   128'(vecs[i].e_mvalid));
            if (vecs[i].chk) begin
                check($sformatf("v%0d m_wdata", i), 128'(m_wdata), 128'(vecs[i].e_data));
                check($sformatf("v%0d m_wstrb", i), 128'(m_wstrb), 128'(vecs[i].e_strb));
                check($sformatf("v%0d m_wlast", i), 128'(m_wlast), 128'(vecs[i].e_last));
            end
            @(posedge clk); #1;
        end

        // 128 -> 32: four lanes, low slice first
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        w_rst_n = 1'b1;
        @(posedge clk); #1;
        w_s_wdata  = 128'h44444444_33333333_22222222_11111111;
        w_s_wstrb  = 16'hFFFF;
        w_s_wlast  = 1'b1;
        w_s_wvalid = 1'b1;
        @(negedge clk);
        check("wide s_wready", 128'(w_s_wready), 128'(1'b1));
        check("wide idle m_wvalid", 128'(w_m_wvalid), 128'(1'b0));
        @(posedge clk); #1;
        w_s_wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("wide lane%0d m_wvalid", k), 128'(w_m_wvalid), 128'(1'b1));
            check($sformatf("wide lane%0d m_wdata", k),  128'(w_m_wdata),  128'(exp_w[k]));
            check($sformatf("wide lane%0d m_wstrb", k),  128'(w_m_wstrb),  128'(4'hF));
            check($sformatf("wide lane%0d m_wlast", k),  128'(w_m_wlast),  128'(k == 3));
            check($sformatf("wide lane%0d s_wready", k), 128'(w_s_wready), 128'(k == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("wide drained m_wvalid", 128'(w_m_wvalid), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
